lsu_mem_port: RTL and testbench
===============================

Name: lsu_mem_port

Overview:
- Executes the memory access for an instruction in the MEM stage, acting on the 16-bit control word produced by the decode-stage control unit.
- Uses mem_re and mem_we to drive a req/gnt/rvalid data-memory bus, handling byte lanes and load sign/zero extension.
- Stalls the pipeline while an access is outstanding.
- Returns load data to writeback.

Parameters:
- CTRL_WIDTH, 16, width of control word; bit map fixed: [7:6] aluop, [5] alusrc, [4] is_branch, [3] mem_re, [2] mem_we, [1] reg_wr_en, [0] is_mem_to_reg
- XLEN, 32, data and address width

Ports:
- clk_i  in  1  clock, rising edge
- rst_n_i  in  1  reset, asynchronous, active-low
- valid_i  in  1  MEM-stage instruction valid
- ctrl_i  in  CTRL_WIDTH  control word of MEM-stage instruction
- funct3_i  in  3  access size/sign
- addr_i  in  XLEN  byte address (ALU result)
- wdata_i  in  XLEN  store data (rs2)
- stall_o  out  1  hold pipeline (combinational)
- done_o  out  1  access complete, one-cycle pulse
- ld_data_o  out  XLEN  formatted load data, valid when done_o=1 and access was a load
- misaligned_o  out  1  access faulted (misaligned/illegal); qualifies done_o
- mem_req_o  out  1  bus request
- mem_we_o  out  1  1=write
- mem_addr_o  out  XLEN  word-aligned address {addr[XLEN-1:2],2'b00}
- mem_be_o  out  4  byte enables
- mem_wdata_o  out  XLEN  lane-replicated store data
- mem_gnt_i  in  1  request accepted
- mem_rvalid_i  in  1  read data valid
- mem_rdata_i  in  XLEN  read data

Behaviour:
- FSM states: IDLE, REQ, WAIT, DONE.
- Reset values: state=IDLE; all mem_* outputs, done_o, misaligned_o, stall_o = 0; ld_data_o = 0.
- start = IDLE & valid_i & (ctrl_i[3] | ctrl_i[2]).
- Illegal access:
  - ctrl_i[3] and ctrl_i[2] both set, or
  - funct3 not in {000,001,010,100,101} for loads / {000,001,010} for stores.
  - Illegal is handled as misaligned.
- Misaligned: half at addr[0]=1; word at addr[1:0]!=0.
- IDLE:
  - On start: latch op, funct3, addr[1:0], byte enables and lane data.
  - If fault: go to DONE with fault flag set, no bus request.
  - Otherwise go to REQ.
- REQ:
  - mem_req_o=1; address, we, be and wdata held stable until grant.
  - On mem_gnt_i with store: go to DONE.
  - On mem_gnt_i with load: if mem_rvalid_i in the same cycle, capture data and go to DONE; else go to WAIT.
- WAIT: mem_req_o=0; on mem_rvalid_i capture formatted data into ld_data_o and go to DONE.
- DONE: done_o=1, misaligned_o=fault flag, stall_o=0; unconditionally go to IDLE. Inputs are ignored this cycle.
- stall_o = start | (state==REQ) | (state==WAIT).
- Minimum latency: aligned store completes in 3 cycles (start, REQ with grant, DONE). Load with grant and rvalid together: same 3 cycles. Each extra wait cycle adds one.
- Byte enables:
  - SB: 4'b0001<<a
  - SH: 4'b0011<<a
  - SW: 4'b1111
  - where a = addr[1:0].
- Store data: SB {4{wdata[7:0]}}, SH {2{wdata[15:0]}}, SW wdata.
- Load formatting: select lane mem_rdata_i >> (8*a).
  - LB/LH: sign-extend.
  - LBU/LHU: zero-extend.
  - LW: pass through.
- Stray mem_gnt_i/mem_rvalid_i in IDLE or DONE: ignored.
- mem_rvalid_i in REQ without gnt: ignored.
- Asynchronous reset mid-access returns to IDLE immediately and drops mem_req_o. No done_o is produced for the aborted access.
- ld_data_o holds its last value outside DONE.

Test Plan:
- SW addr=0x100, wdata=0xDEADBEEF, gnt on first REQ cycle -> mem_req_o one cycle, mem_addr_o=0x100, be=1111, mem_we_o=1; done_o on cycle 3; stall_o high cycles 1–2.
- LB addr=0x203, rdata=0x80xxxxxx, gnt+rvalid together -> be=1000, ld_data_o=0xFFFFFF80, done_o on cycle 3.
- LHU addr=0x302, gnt held low 2 cycles, rvalid 3 cycles after gnt -> req held stable across gnt wait; ld_data_o=0x0000ABCD from rdata=0xABCD1234; stall_o low only in DONE.
- SH addr=0x101 -> no mem_req_o; done_o=1 and misaligned_o=1 on cycle 2. Also ctrl with mem_re=mem_we=1 -> same fault response.
- SB addr=0x2 wdata=0x5A -> mem_wdata_o=0x5A5A5A5A, be=0100.
- Assert rst_n_i low while in WAIT -> mem_req_o=0, state IDLE; subsequent stray rvalid produces no done_o.

Source files
------------

// File: rtl/lsu_mem_port.sv
// MEM-stage load/store unit: turns the decoded mem_re/mem_we control bits into a
// single req/gnt/rvalid data-memory transaction with byte lanes and load extension.
`timescale 1ns/1ps
module lsu_mem_port #(
  parameter int CTRL_WIDTH = 16,
  parameter int XLEN       = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  valid_i,
  input  logic [CTRL_WIDTH-1:0] ctrl_i,
  input  logic [2:0]            funct3_i,
  input  logic [XLEN-1:0]       addr_i,
  input  logic [XLEN-1:0]       wdata_i,
  output logic                  stall_o,
  output logic                  done_o,
  output logic [XLEN-1:0]       ld_data_o,
  output logic                  misaligned_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [XLEN-1:0]       mem_addr_o,
  output logic [3:0]            mem_be_o,
  output logic [XLEN-1:0]       mem_wdata_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [XLEN-1:0]       mem_rdata_i
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_t;

  state_t          state_reg, state_next;
  logic            is_load_reg;
  logic [1:0]      size_reg;
  logic            unsigned_reg;
  logic [1:0]      a_reg;
  logic            fault_reg;
  logic [XLEN-1:0] addr_reg;
  logic [3:0]      be_reg;
  logic [XLEN-1:0] wdata_reg;
  logic [XLEN-1:0] ld_data_reg;

  logic            is_re, is_we, start, legal, misal, fault, capture, in_req;
  logic [1:0]      a;
  logic [3:0]      be_calc;
  logic [XLEN-1:0] wdata_calc, lane, ld_fmt;
  logic            unused_ctrl;

  assign unused_ctrl = ^{ctrl_i[CTRL_WIDTH-1:4], ctrl_i[1:0]};

  // Decode of the incoming access; only meaningful in the cycle start is high.
  always_comb begin
    is_re = ctrl_i[3];
    is_we = ctrl_i[2];
    a     = addr_i[1:0];
    start = (state_reg == IDLE) & valid_i & (is_re | is_we);
    legal = 1'b0;
    if (is_re & is_we)
      legal = 1'b0;
    else if (is_re)
      legal = funct3_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    else
      legal = funct3_i inside {3'b000, 3'b001, 3'b010};
    misal = ((funct3_i[1:0] == 2'b01) & a[0]) | ((funct3_i[1:0] == 2'b10) & (a != 2'b00));
    fault = ~legal | misal;
    case (funct3_i[1:0])
      2'b00: begin
        be_calc    = 4'b0001 << a;
        wdata_calc = {(XLEN/8){wdata_i[7:0]}};
      end
      2'b01: begin
        be_calc    = 4'b0011 << a;
        wdata_calc = {(XLEN/16){wdata_i[15:0]}};
      end
      default: begin
        be_calc    = 4'b1111;
        wdata_calc = wdata_i;
      end
    endcase
  end

  // Load formatting works from the lane offset latched at start, not the live address.
  always_comb begin
    lane = mem_rdata_i >> {a_reg, 3'b000};
    case (size_reg)
      2'b00:   ld_fmt = {{(XLEN-8){~unsigned_reg & lane[7]}}, lane[7:0]};
      2'b01:   ld_fmt = {{(XLEN-16){~unsigned_reg & lane[15]}}, lane[15:0]};
      default: ld_fmt = lane;
    endcase
  end

  assign capture = ((state_reg == REQ) & mem_gnt_i & is_load_reg & mem_rvalid_i)
                 | ((state_reg == WAIT) & mem_rvalid_i);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (start) state_next = fault ? DONE : REQ;
      REQ: begin
        if (mem_gnt_i) begin
          if (!is_load_reg || mem_rvalid_i) state_next = DONE;
          else                              state_next = WAIT;
        end
      end
      WAIT:    if (mem_rvalid_i) state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_reg    <= IDLE;
      is_load_reg  <= 1'b0;
      size_reg     <= 2'b00;
      unsigned_reg <= 1'b0;
      a_reg        <= 2'b00;
      fault_reg    <= 1'b0;
      addr_reg     <= '0;
      be_reg       <= 4'b0000;
      wdata_reg    <= '0;
      ld_data_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (start) begin
        is_load_reg  <= is_re & ~is_we;
        size_reg     <= funct3_i[1:0];
        unsigned_reg <= funct3_i[2];
        a_reg        <= a;
        fault_reg    <= fault;
        addr_reg     <= {addr_i[XLEN-1:2], 2'b00};
        be_reg       <= be_calc;
        wdata_reg    <= wdata_calc;
      end
      if (capture) ld_data_reg <= ld_fmt;
    end
  end

  // Bus outputs are quiet outside REQ so stray lanes never leak onto the bus.
  assign in_req       = (state_reg == REQ);
  assign mem_req_o    = in_req;
  assign mem_we_o     = in_req & ~is_load_reg;
  assign mem_addr_o   = in_req ? addr_reg : '0;
  assign mem_be_o     = in_req ? be_reg : 4'b0000;
  assign mem_wdata_o  = in_req ? wdata_reg : '0;
  assign done_o       = (state_reg == DONE);
  assign misaligned_o = (state_reg == DONE) & fault_reg;
  assign stall_o      = start | in_req | (state_reg == WAIT);
  assign ld_data_o    = ld_data_reg;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Bench for lsu_mem_port: per-scenario tasks, expected results queued at stimulus
// time and popped when the access completes.
`timescale 1ns/1ps
module tb_lsu_mem_port;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        valid_i = 1'b0;
  logic [15:0] ctrl_i = '0;
  logic [2:0]  funct3_i = '0;
  logic [31:0] addr_i = '0;
  logic [31:0] wdata_i = '0;
  logic        stall_o, done_o, misaligned_o;
  logic [31:0] ld_data_o;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_gnt_i = 1'b0;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;

  lsu_mem_port #(.CTRL_WIDTH(16), .XLEN(32)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .valid_i(valid_i), .ctrl_i(ctrl_i),
    .funct3_i(funct3_i), .addr_i(addr_i), .wdata_i(wdata_i), .stall_o(stall_o),
    .done_o(done_o), .ld_data_o(ld_data_o), .misaligned_o(misaligned_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  localparam logic [15:0] C_LD  = 16'h000B;
  localparam logic [15:0] C_ST  = 16'h0024;
  localparam logic [15:0] C_BAD = 16'h000C;

  typedef struct {
    int          lat;
    logic        mis;
    logic        is_load;
    logic [31:0] ld;
    logic [31:0] maddr;
    logic [3:0]  be;
    logic [31:0] wd;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  int          o_done, o_req;
  logic        o_mis, o_we, o_stable;
  logic [31:0] o_ld, o_addr, o_wd, o_stall;
  logic [3:0]  o_be;

  function automatic logic f_fault(logic re, logic we, logic [2:0] f3, logic [1:0] a);
    logic legal;
    if (re && we) return 1'b1;
    if (re) legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    else    legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
    if (!legal) return 1'b1;
    if (f3[1:0] == 2'b01) return a[0];
    if (f3[1:0] == 2'b10) return (a != 2'b00);
    return 1'b0;
  endfunction

  function automatic logic [3:0] f_be(logic [2:0] f3, logic [1:0] a);
    if (f3[1:0] == 2'b00) begin
      case (a)
        2'd0: return 4'b0001;
        2'd1: return 4'b0010;
        2'd2: return 4'b0100;
        default: return 4'b1000;
      endcase
    end
    if (f3[1:0] == 2'b01) return a[1] ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] f_wd(logic [2:0] f3, logic [31:0] wd);
    if (f3[1:0] == 2'b00) return {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
    if (f3[1:0] == 2'b01) return {wd[15:0], wd[15:0]};
    return wd;
  endfunction

  function automatic logic [31:0] f_ld(logic [2:0] f3, logic [1:0] a, logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    case (a)
      2'd0: b = rd[7:0];
      2'd1: b = rd[15:8];
      2'd2: b = rd[23:16];
      default: b = rd[31:24];
    endcase
    h = a[1] ? rd[31:16] : rd[15:0];
    case (f3)
      3'b000: return {{24{b[7]}}, b};
      3'b100: return {24'h0, b};
      3'b001: return {{16{h[15]}}, h};
      3'b101: return {16'h0, h};
      default: return rd;
    endcase
  endfunction

  // Scoreboard entry for one access; g = grant delay, r = rvalid delay after grant.
  task automatic expect_push(input logic [15:0] c, input logic [2:0] f3, input logic [31:0] ad,
                             input logic [31:0] wd, input logic [31:0] rd, input int g, input int r);
    exp_t e;
    e.mis     = f_fault(c[3], c[2], f3, ad[1:0]);
    e.is_load = c[3] & ~c[2];
    e.lat     = e.mis ? 2 : (e.is_load ? 3 + g + r : 3 + g);
    e.ld      = f_ld(f3, ad[1:0], rd);
    e.maddr   = {ad[31:2], 2'b00};
    e.be      = f_be(f3, ad[1:0]);
    e.wd      = f_wd(f3, wd);
    sb_q.push_back(e);
  endtask

  // Drives one access and a responder with fixed gnt/rvalid timing; records what the DUT did.
  task automatic drive_access(input logic [15:0] c, input logic [2:0] f3, input logic [31:0] ad,
                              input logic [31:0] wd, input logic [31:0] rd, input int g, input int r);
    bit seen;
    seen = 0;
    o_done = -1; o_req = 0; o_mis = 0; o_we = 0; o_stable = 1;
    o_ld = '0; o_addr = '0; o_wd = '0; o_stall = '0; o_be = '0;
    valid_i = 1'b1; ctrl_i = c; funct3_i = f3; addr_i = ad; wdata_i = wd;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      if (cyc > 1) begin
        valid_i      = 1'b0;
        mem_gnt_i    = (cyc == 2 + g);
        mem_rvalid_i = (r >= 0) && (cyc == 2 + g + r);
        mem_rdata_i  = mem_rvalid_i ? rd : 32'h0;
      end
      @(negedge clk_i);
      o_stall[cyc-1] = stall_o;
      if (mem_req_o) begin
        if (o_req == 0) begin
          o_addr = mem_addr_o; o_be = mem_be_o; o_we = mem_we_o; o_wd = mem_wdata_o;
        end else if (mem_addr_o !== o_addr || mem_be_o !== o_be || mem_we_o !== o_we ||
                     mem_wdata_o !== o_wd) begin
          o_stable = 1'b0;
        end
        o_req++;
      end
      if (done_o) begin
        o_done = cyc; o_mis = misaligned_o; o_ld = ld_data_o; seen = 1;
      end
      @(posedge clk_i); #1;
      if (seen) break;
    end
    valid_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
  endtask

  function automatic logic [31:0] stall_mask(int lat);
    return (32'h1 << (lat - 1)) - 32'h1;
  endfunction

  task automatic test_reset();
    rst_n_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    checks++; if (stall_o !== 1'b0 || done_o !== 1'b0 || misaligned_o !== 1'b0) begin
      errors++; $display("FAIL reset_ctl: stall=%b done=%b mis=%b want 0 0 0", stall_o, done_o, misaligned_o); end
    checks++; if (mem_req_o !== 1'b0 || mem_we_o !== 1'b0 || mem_be_o !== 4'h0) begin
      errors++; $display("FAIL reset_bus: req=%b we=%b be=%h want 0 0 0", mem_req_o, mem_we_o, mem_be_o); end
    checks++; if (mem_addr_o !== 32'h0 || mem_wdata_o !== 32'h0 || ld_data_o !== 32'h0) begin
      errors++; $display("FAIL reset_data: addr=%h wdata=%h ld=%h want 0", mem_addr_o, mem_wdata_o, ld_data_o); end
    rst_n_i = 1'b1;
    @(posedge clk_i); #1;
    $display("reset: outputs checked");
  endtask

  task automatic test_sw();
    exp_t e;
    expect_push(C_ST, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0, -1);
    drive_access(C_ST, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0, -1);
    e = sb_q.pop_front();
    checks++; if (o_done !== 3 || o_done !== e.lat) begin errors++; $display("FAIL sw_done_cycle: got %0d want %0d", o_done, e.lat); end
    checks++; if (o_mis !== e.mis) begin errors++; $display("FAIL sw_mis: got %b want %b", o_mis, e.mis); end
    checks++; if (o_req !== 1) begin errors++; $display("FAIL sw_req_cycles: got %0d want 1", o_req); end
    checks++; if (o_addr !== e.maddr || o_be !== e.be || o_we !== 1'b1) begin
      errors++; $display("FAIL sw_bus: addr=%h be=%b we=%b want %h %b 1", o_addr, o_be, o_we, e.maddr, e.be); end
    checks++; if (o_wd !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_wdata: got %h want deadbeef", o_wd); end
    checks++; if (o_stall !== stall_mask(e.lat)) begin errors++; $display("FAIL sw_stall: got %h want %h", o_stall, stall_mask(e.lat)); end
    $display("sw  addr=00000100 done@%0d be=%b", o_done, o_be);
  endtask

  task automatic test_lb();
    exp_t e;
    expect_push(C_LD, 3'b000, 32'h203, 32'h0, 32'h80123456, 0, 0);
    drive_access(C_LD, 3'b000, 32'h203, 32'h0, 32'h80123456, 0, 0);
    e = sb_q.pop_front();
    checks++; if (o_done !== e.lat) begin errors++; $display("FAIL lb_done_cycle: got %0d want %0d", o_done, e.lat); end
    checks++; if (o_be !== 4'b1000 || o_we !== 1'b0 || o_addr !== 32'h200) begin
      errors++; $display("FAIL lb_bus: be=%b we=%b addr=%h want 1000 0 00000200", o_be, o_we, o_addr); end
    checks++; if (o_ld !== 32'hFFFFFF80 || o_ld !== e.ld) begin errors++; $display("FAIL lb_data: got %h want ffffff80", o_ld); end
    $display("lb  addr=00000203 done@%0d ld=%h", o_done, o_ld);
  endtask

  task automatic test_lhu_wait();
    exp_t e;
    expect_push(C_LD, 3'b101, 32'h302, 32'h0, 32'hABCD1234, 2, 3);
    drive_access(C_LD, 3'b101, 32'h302, 32'h0, 32'hABCD1234, 2, 3);
    e = sb_q.pop_front();
    checks++; if (o_done !== e.lat) begin errors++; $display("FAIL lhu_done_cycle: got %0d want %0d", o_done, e.lat); end
    checks++; if (o_req !== 3 || o_stable !== 1'b1) begin errors++; $display("FAIL lhu_req_hold: cycles=%0d stable=%b want 3 1", o_req, o_stable); end
    checks++; if (o_be !== 4'b1100) begin errors++; $display("FAIL lhu_be: got %b want 1100", o_be); end
    checks++; if (o_ld !== 32'h0000ABCD) begin errors++; $display("FAIL lhu_data: got %h want 0000abcd", o_ld); end
    checks++; if (o_stall !== stall_mask(e.lat)) begin errors++; $display("FAIL lhu_stall: got %h want %h", o_stall, stall_mask(e.lat)); end
    $display("lhu addr=00000302 done@%0d ld=%h", o_done, o_ld);
  endtask

  task automatic test_sb_lanes();
    exp_t e;
    expect_push(C_ST, 3'b000, 32'h2, 32'h0000005A, 32'h0, 1, -1);
    drive_access(C_ST, 3'b000, 32'h2, 32'h0000005A, 32'h0, 1, -1);
    e = sb_q.pop_front();
    checks++; if (o_done !== e.lat) begin errors++; $display("FAIL sb_done_cycle: got %0d want %0d", o_done, e.lat); end
    checks++; if (o_wd !== 32'h5A5A5A5A || o_be !== 4'b0100) begin
      errors++; $display("FAIL sb_lanes: wdata=%h be=%b want 5a5a5a5a 0100", o_wd, o_be); end
    checks++; if (o_ld !== 32'h0000ABCD) begin errors++; $display("FAIL sb_ld_hold: got %h want 0000abcd", o_ld); end
    $display("sb  addr=00000002 done@%0d wdata=%h", o_done, o_wd);
  endtask

  task automatic test_fault();
    exp_t e;
    logic [15:0] c_tab [3];
    logic [2:0]  f_tab [3];
    c_tab = '{C_ST, C_BAD, C_LD};
    f_tab = '{3'b001, 3'b010, 3'b011};
    for (int i = 0; i < 3; i++) begin
      expect_push(c_tab[i], f_tab[i], 32'h101 - 32'(i), 32'h1234, 32'h0, 0, 0);
      drive_access(c_tab[i], f_tab[i], 32'h101 - 32'(i), 32'h1234, 32'h0, 0, 0);
      e = sb_q.pop_front();
      checks++; if (o_done !== 2 || o_mis !== 1'b1 || o_mis !== e.mis) begin
        errors++; $display("FAIL fault_%0d: done@%0d mis=%b want done@2 mis=1", i, o_done, o_mis); end
      checks++; if (o_req !== 0) begin errors++; $display("FAIL fault_%0d_req: got %0d cycles want 0", i, o_req); end
      $display("fault ctrl=%h f3=%b done@%0d mis=%b", c_tab[i], f_tab[i], o_done, o_mis);
    end
  endtask

  task automatic test_reset_abort();
    bit bad;
    bad = 0;
    valid_i = 1'b1; ctrl_i = C_LD; funct3_i = 3'b010; addr_i = 32'h400;
    @(posedge clk_i); #1;
    valid_i = 1'b0; mem_gnt_i = 1'b1;
    @(negedge clk_i);
    checks++; if (mem_req_o !== 1'b1) begin errors++; $display("FAIL abort_req: got %b want 1", mem_req_o); end
    @(posedge clk_i); #1;
    mem_gnt_i = 1'b0;
    @(negedge clk_i);
    checks++; if (mem_req_o !== 1'b0 || stall_o !== 1'b1) begin
      errors++; $display("FAIL abort_wait: req=%b stall=%b want 0 1", mem_req_o, stall_o); end
    #2 rst_n_i = 1'b0;
    #1;
    checks++; if (mem_req_o !== 1'b0 || stall_o !== 1'b0 || done_o !== 1'b0) begin
      errors++; $display("FAIL abort_async: req=%b stall=%b done=%b want 0 0 0", mem_req_o, stall_o, done_o); end
    @(posedge clk_i); #1;
    rst_n_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hFFFF0000;
      @(negedge clk_i);
      if (done_o !== 1'b0 || stall_o !== 1'b0 || mem_req_o !== 1'b0) bad = 1;
      @(posedge clk_i); #1;
    end
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    checks++; if (bad) begin errors++; $display("FAIL abort_stray: done/stall/req seen after reset, want none"); end
    $display("abort: reset during WAIT, stray gnt/rvalid ignored");
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [15:0] c;
    logic [2:0]  f3;
    logic [31:0] ad, wd, rd;
    int          g, r;
    logic [2:0]  ld_f3 [5];
    ld_f3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    for (int i = 0; i < 16; i++) begin
      c  = ($urandom_range(0, 1) == 1) ? C_LD : C_ST;
      if (i == 7) c = C_BAD;
      f3 = (c == C_LD) ? ld_f3[$urandom_range(0, 4)] : 3'($urandom_range(0, 2));
      ad = {20'h0, 10'($urandom_range(0, 1023)), 2'($urandom_range(0, 3))};
      wd = $urandom; rd = $urandom;
      g  = $urandom_range(0, 2);
      r  = (c == C_LD) ? int'($urandom_range(0, 2)) : -1;
      expect_push(c, f3, ad, wd, rd, g, r);
      drive_access(c, f3, ad, wd, rd, g, r);
      e = sb_q.pop_front();
      checks++; if (o_done !== e.lat || o_mis !== e.mis) begin
        errors++; $display("FAIL b2b_%0d_done: done@%0d mis=%b want done@%0d mis=%b", i, o_done, o_mis, e.lat, e.mis); end
      checks++; if (o_stall !== stall_mask(e.lat)) begin
        errors++; $display("FAIL b2b_%0d_stall: got %h want %h", i, o_stall, stall_mask(e.lat)); end
      if (!e.mis) begin
        checks++; if (o_addr !== e.maddr || o_be !== e.be || o_we !== ~e.is_load || o_req !== g + 1 || o_stable !== 1'b1) begin
          errors++; $display("FAIL b2b_%0d_bus: addr=%h be=%b we=%b req=%0d stable=%b want %h %b %b %0d 1",
                             i, o_addr, o_be, o_we, o_req, o_stable, e.maddr, e.be, ~e.is_load, g + 1); end
        if (e.is_load) begin
          checks++; if (o_ld !== e.ld) begin errors++; $display("FAIL b2b_%0d_ld: got %h want %h", i, o_ld, e.ld); end
        end else begin
          checks++; if (o_wd !== e.wd) begin errors++; $display("FAIL b2b_%0d_wd: got %h want %h", i, o_wd, e.wd); end
        end
      end
      $display("b2b %0d ctrl=%h f3=%b addr=%h g=%0d r=%0d done@%0d mis=%b ld=%h", i, c, f3, ad, g, r, o_done, o_mis, o_ld);
    end
  endtask

  initial begin
    test_reset();
    test_sw();
    test_lb();
    test_lhu_wait();
    test_sb_lanes();
    test_fault();
    test_reset_abort();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
